// File: rtl/clk_div_pkg.sv
// Shared constants and divisor clamping for the clock-divider bank.
package clk_div_pkg;

    localparam int DEF_CNT_W   = 20;
    localparam int DEF_DIV_RST = 1000;
    localparam int DIV_MIN     = 2;

    // Divisors below DIV_MIN cannot form a high and a low phase, so they are raised to it.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Divisor configuration bus: valid/ready write of one channel's divisor plus an error pulse.
interface clk_div_if import clk_div_pkg::*; #(
    parameter int CH    = 4,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and pending divisor, registered clk_out/tick.
module clk_div_chan import clk_div_pkg::*; #(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_RST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] div_n;
    logic             wrap;
    logic             apply;

    assign wrap  = (cnt == div_act - CNT_W'(1));
    // A pending divisor lands only on a period boundary: sync, a running wrap, or while idle.
    assign apply = pend && (sync || !en || wrap);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_n = cnt;
        div_n = div_act;
        if (apply) div_n = pend_div;
        if (sync || apply) cnt_n = '0;
        else if (en)       cnt_n = wrap ? '0 : cnt + CNT_W'(1);
    end

    // NOTE: state uses <= so each flop samples its peers' pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= CNT_W'(DEF_DIV);
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            div_act <= div_n;
            clk_out <= (cnt_n >= (div_n >> 1));
            tick    <= en && !sync && (cnt_n == div_n - CNT_W'(1));
            if (wr)         pend <= 1'b1;
            else if (apply) pend <= 1'b0;
        end
    end

    // NOTE: pend_div is pure data qualified by pend, so it deliberately has no reset.
    always_ff @(posedge clk) begin
        if (wr) pend_div <= wr_div;
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CH programmable clock dividers sharing one config port and one sync pulse.
module clk_div_bank import clk_div_pkg::*; #(
    parameter int CH      = 4,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_RST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] en,
    input  logic          sync,
    clk_div_if.slave      cfg,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick
);

    logic [CH-1:0]    pend;
    logic             hs;
    logic [CNT_W-1:0] div_c;

    // Only one update may be outstanding bank-wide, which keeps the pending slots simple.
    assign cfg.cfg_ready = ~|pend;
    assign hs            = cfg.cfg_valid && cfg.cfg_ready;
    assign div_c         = CNT_W'(clamp_div(32'(cfg.cfg_div)));

    always_ff @(posedge clk) begin
        if (rst) cfg.cfg_err <= 1'b0;
        else     cfg.cfg_err <= hs && (int'(cfg.cfg_ch) >= CH);
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (hs && (int'(cfg.cfg_ch) == i)),
            .wr_div  (div_c),
            .pend    (pend[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
